// File: rtl/tof_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tof_sched_pkg
// Brief    : Shared types and the round-robin pick for the ToF readout scheduler
// Revision : 1.0 - initial release
// ============================================================================
package tof_sched_pkg;

    localparam int N_SENSORS = 8;

    typedef struct packed {
        logic [2:0]  sensor_no;
        logic [5:0]  sensor_index;
        logic [15:0] distance;
    } tof_frame_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CAPTURE = 2'd2
    } sched_state_t;

    // First requesting channel found scanning ptr, ptr+1, ... with 3-bit wrap.
    function automatic logic [2:0] rr_pick(input logic [N_SENSORS-1:0] req,
                                           input logic [2:0]           ptr);
        logic [2:0] grant;
        logic [2:0] idx;
        logic       found;
        grant = ptr;
        found = 1'b0;
        for (int i = 0; i < N_SENSORS; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_frame_fifo
// Brief    : Single-clock show-ahead FIFO; head reads as zero while empty
// Revision : 1.0 - initial release
// ============================================================================
module sync_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tof_readout_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tof_readout_scheduler
// Brief    : Round-robin drain of 8 ToF result channels into a tagged frame stream
// Revision : 1.0 - initial release
// ============================================================================
module tof_readout_scheduler
    import tof_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SENSORS-1:0] ready_in,
    input  logic [21:0]          data_in,
    output logic [2:0]           tof_index,
    input  logic [N_SENSORS-1:0] enable_mask,
    output logic [24:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           overrun_cnt,
    output logic                 busy
);
    sched_state_t         state_q, state_d;
    logic [N_SENSORS-1:0] ready_q;
    logic [N_SENSORS-1:0] pending_q, pending_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           tof_index_q, tof_index_d;
    logic [7:0]           overrun_q, overrun_d;

    logic [N_SENSORS-1:0] rise;
    logic [N_SENSORS-1:0] clr;
    logic [N_SENSORS-1:0] ovr_bits;
    logic [N_SENSORS-1:0] eligible;
    logic [8:0]           ovr_sum;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    tof_frame_t           push_frame;
    tof_frame_t           head_frame;

    // A fresh rise always re-arms pending, even on the bit being cleared.
    always_comb begin
        rise      = ready_in & ~ready_q & enable_mask;
        clr       = (state_q == CAPTURE) ? (N_SENSORS'(1) << tof_index_q) : '0;
        pending_d = (pending_q & ~clr) | rise;
        ovr_bits  = rise & pending_q & ~clr;
        ovr_sum   = {1'b0, overrun_q} + 9'($countones(ovr_bits));
        overrun_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end

    always_comb begin
        state_d     = state_q;
        tof_index_d = tof_index_q;
        rr_ptr_d    = rr_ptr_q;
        push        = 1'b0;
        eligible    = pending_q & enable_mask;
        case (state_q)
            IDLE: begin
                if ((eligible != '0) && !fifo_full) begin
                    tof_index_d = rr_pick(eligible, rr_ptr_q);
                    state_d     = SELECT;
                end
            end
            SELECT:  state_d = CAPTURE;
            CAPTURE: begin
                push     = 1'b1;
                rr_ptr_d = tof_index_q + 3'd1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ready_q     <= '0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            tof_index_q <= '0;
            overrun_q   <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_in;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            tof_index_q <= tof_index_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        push_frame              = '0;
        push_frame.sensor_no    = tof_index_q;
        push_frame.sensor_index = data_in[21:16];
        push_frame.distance     = data_in[15:0];
    end

    sync_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(tof_frame_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (out_ready),
        .wdata_i (push_frame),
        .rdata_o (head_frame),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tof_index   = tof_index_q;
    assign out_data    = head_frame;
    assign out_valid   = ~fifo_empty;
    assign overrun_cnt = overrun_q;
    assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tof_readout_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tof_readout_scheduler
// Brief    : Vector table, directed corner sequences and randomized scoreboard run
// Revision : 1.0 - initial release
// ============================================================================
module tb_tof_readout_scheduler;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ready_in;
    logic [21:0] data_in;
    logic [2:0]  tof_index;
    logic [7:0]  enable_mask;
    logic [24:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  overrun_cnt;
    logic        busy;

    logic [21:0] sens_data [8];
    logic [24:0] got_q [$];
    longint      got_t [$];
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [7:0]  rdy;
        logic [7:0]  en;
        int          n;
        logic [23:0] order;
    } vec_t;
    vec_t vt [7];

    tof_readout_scheduler #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .ready_in    (ready_in),
        .data_in     (data_in),
        .tof_index   (tof_index),
        .enable_mask (enable_mask),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun_cnt (overrun_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Upstream model: data_in follows the selected channel's latest result.
    assign data_in = sens_data[tof_index];

    // Inputs only move just after posedge, so the negedge view is what the next edge pops.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_t.push_back($time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic init_data();
        for (int s = 0; s < 8; s++) sens_data[s] = {6'(s + 10), 16'(s * 1111 + 7)};
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        ready_in    = '0;
        out_ready   = 1'b1;
        enable_mask = 8'hFF;
        init_data();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic pulse(input logic [7:0] m);
        ready_in = m;
        tick();
        ready_in = '0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string nm);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        repeat (6) tick();
        check(nm, 32'(got_q.size()), 32'(n));
    endtask

    task automatic check_frame(input string nm, input logic [2:0] s);
        logic [24:0] f;
        if (got_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no frame, expected sensor %0d", nm, s);
        end else begin
            f = got_q.pop_front();
            void'(got_t.pop_front());
            check(nm, 32'(f), 32'({s, sens_data[s]}));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  mask;
        logic [7:0]  outst;
        logic [21:0] expd [8];
        logic [24:0] f;
        int          c;

        vt[0] = '{8'h08, 8'hFF, 1, 24'd3};
        vt[1] = '{8'hFF, 8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        vt[2] = '{8'h21, 8'hFF, 2, {18'd0, 3'd5, 3'd0}};
        vt[3] = '{8'hFF, 8'hFE, 7, {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}};
        vt[4] = '{8'hA5, 8'h0F, 2, {18'd0, 3'd2, 3'd0}};
        vt[5] = '{8'h00, 8'hFF, 0, 24'd0};
        vt[6] = '{8'h81, 8'h7F, 1, 24'd0};

        // Reset values while reset is held
        reset = 1'b0; ready_in = '0; out_ready = 1'b0; enable_mask = 8'hFF;
        init_data();
        repeat (2) tick();
        check("rst_tof_index", 32'(tof_index), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data), 0);
        check("rst_overrun",   32'(overrun_cnt), 0);
        check("rst_busy",      32'(busy), 0);

        // Single-sensor latency
        do_reset();
        sens_data[3] = {6'd5, 16'd1234};
        pulse(8'h08);
        tick();
        check("lat_tof_index", 32'(tof_index), 3);
        check("lat_valid_t1",  32'(out_valid), 0);
        tick();
        check("lat_valid_t2",  32'(out_valid), 0);
        check("lat_busy",      32'(busy), 1);
        tick();
        check("lat_valid_t3",  32'(out_valid), 1);
        check("lat_out_data",  32'(out_data), 32'({3'd3, 6'd5, 16'd1234}));
        check("lat_overrun",   32'(overrun_cnt), 0);

        // Table-driven bursts from a fresh reset
        foreach (vt[k]) begin
            do_reset();
            enable_mask = vt[k].en;
            pulse(vt[k].rdy);
            wait_frames(vt[k].n, 60, "vec_count");
            if (vt[k].rdy == 8'hFF && vt[k].en == 8'hFF && got_t.size() == 8)
                check("vec_spacing", 32'(got_t[7] - got_t[0]), 32'd210);
            for (int i = 0; i < vt[k].n; i++) check_frame("vec_frame", vt[k].order[3*i +: 3]);
            check("vec_busy", 32'(busy), 0);
        end

        // Round-robin pointer follows the last grant
        do_reset();
        pulse(8'h04);
        wait_frames(1, 30, "rr_first_count");
        check_frame("rr_first", 3'd2);
        pulse(8'h21);
        wait_frames(2, 30, "rr_21_count");
        check_frame("rr_21_a", 3'd5);
        check_frame("rr_21_b", 3'd0);
        pulse(8'h03);
        wait_frames(2, 30, "rr_03_count");
        check_frame("rr_03_a", 3'd1);
        check_frame("rr_03_b", 3'd0);

        // Backpressure: FIFO fills with 0..3, rest wait without loss
        do_reset();
        out_ready = 1'b0;
        pulse(8'hFF);
        repeat (30) tick();
        check("bp_valid",   32'(out_valid), 1);
        check("bp_busy",    32'(busy), 0);
        check("bp_head",    32'(out_data), 32'({3'd0, sens_data[0]}));
        out_ready = 1'b1;
        wait_frames(8, 60, "bp_count");
        for (int i = 0; i < 8; i++) check_frame("bp_frame", 3'(i));

        // Coalescing while stalled: one frame carrying the latest data
        do_reset();
        out_ready = 1'b0;
        pulse(8'h1B);
        repeat (20) tick();
        sens_data[2] = {6'd9, 16'd100};
        pulse(8'h04);
        tick();
        sens_data[2] = {6'd9, 16'd200};
        pulse(8'h04);
        tick();
        check("coal_overrun", 32'(overrun_cnt), 1);
        out_ready = 1'b1;
        wait_frames(5, 60, "coal_count");
        check_frame("coal_f0", 3'd0);
        check_frame("coal_f1", 3'd1);
        check_frame("coal_f3", 3'd3);
        check_frame("coal_f4", 3'd4);
        check_frame("coal_f2", 3'd2);

        // Multi-bit overrun popcount, then saturation at 255
        do_reset();
        out_ready = 1'b0;
        pulse(8'h0F);
        repeat (15) tick();
        pulse(8'hF0);
        tick();
        pulse(8'hF0);
        tick();
        check("ovr_popcount", 32'(overrun_cnt), 4);
        for (int i = 0; i < 260; i++) begin
            pulse(8'h04);
            tick();
        end
        check("ovr_saturate", 32'(overrun_cnt), 255);

        // Masked channel never latches; latched-then-masked waits for unmask
        do_reset();
        enable_mask = 8'hFE;
        pulse(8'h01);
        wait_frames(0, 20, "mask_none");
        check("mask_overrun", 32'(overrun_cnt), 0);
        do_reset();
        out_ready = 1'b0;
        pulse(8'h0F);
        repeat (20) tick();
        pulse(8'h40);
        tick();
        enable_mask = 8'hBF;
        out_ready   = 1'b1;
        repeat (40) tick();
        check("mask_held_count", 32'(got_q.size()), 4);
        for (int i = 0; i < 4; i++) check_frame("mask_held_frame", 3'(i));
        enable_mask = 8'hFF;
        wait_frames(1, 30, "mask_unmask_count");
        check_frame("mask_unmask_frame", 3'd6);

        // Reset during CAPTURE discards the in-flight frame
        do_reset();
        pulse(8'h08);
        tick();
        tick();
        check("abort_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("abort_tof_index", 32'(tof_index), 0);
        check("abort_valid",     32'(out_valid), 0);
        check("abort_data",      32'(out_data), 0);
        check("abort_busy_rst",  32'(busy), 0);
        tick();
        tick();
        reset = 1'b1;
        wait_frames(0, 20, "abort_no_frame");

        // Randomized run against a transaction-level scoreboard
        do_reset();
        mask        = 8'($urandom_range(1, 255));
        enable_mask = mask;
        outst       = '0;
        for (int s = 0; s < 8; s++) expd[s] = '0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            logic [7:0] r;
            r = '0;
            if (cyc < 600) begin
                for (int s = 0; s < 8; s++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        if (!mask[s]) begin
                            r[s] = 1'b1;
                        end else if (!outst[s]) begin
                            r[s]         = 1'b1;
                            outst[s]     = 1'b1;
                            expd[s]      = 22'($urandom);
                            sens_data[s] = expd[s];
                        end
                    end
                end
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                out_ready = 1'b1;
            end
            ready_in = r;
            tick();
            while (got_q.size() > 0) begin
                f = got_q.pop_front();
                void'(got_t.pop_front());
                check("rand_frame", {9'd0, outst[f[24:22]], f[21:0]}, {9'd0, 1'b1, expd[f[24:22]]});
                outst[f[24:22]] = 1'b0;
            end
        end
        ready_in = '0;
        check("rand_drained", 32'(outst), 0);
        check("rand_overrun", 32'(overrun_cnt), 0);
        check("rand_idle",    32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
